// File: rtl/div_arbiter.sv
// Round-robin front end that shares one iterative Q3.12 divider among N_REQ requesters.
// Holds operands stable for the whole divide and aborts a hung divider with a watchdog.
module div_arbiter #(
   parameter int WIDTH   = 16,
   parameter int Q_BITS  = 12,
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 128,
   localparam int GW     = $clog2(N_REQ),
   localparam int CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_dividend,
   input  logic [N_REQ*WIDTH-1:0] req_divisor,
   output logic [N_REQ-1:0]       req_ready,
   output logic [N_REQ-1:0]       rsp_valid,
   input  logic [N_REQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]       rsp_quotient,
   output logic                   rsp_err,
   output logic                   div_start,
   output logic [WIDTH-1:0]       div_dividend,
   output logic [WIDTH-1:0]       div_divisor,
   input  logic                   div_ready,
   input  logic                   div_valid,
   input  logic [WIDTH-1:0]       div_quotient,
   output logic                   div_flush,
   output logic                   busy,
   output logic [GW-1:0]          grant_id
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]       r_state;
   logic [GW-1:0]    r_last_grant;
   logic [GW-1:0]    r_grant_id;
   logic [WIDTH-1:0] r_div_dividend;
   logic [WIDTH-1:0] r_div_divisor;
   logic [WIDTH-1:0] r_rsp_quotient;
   logic             r_rsp_err;
   logic [CW-1:0]    r_cnt;

   logic [GW-1:0]    w_sel;
   logic             w_found;
   logic             w_grant;
   logic             w_timeout;

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin : rr_search
      int v_idx;
      w_sel   = '0;
      w_found = 1'b0;
      v_idx   = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         v_idx = (int'(r_last_grant) + i) % N_REQ;
         if (!w_found && req_valid[v_idx]) begin
            w_found = 1'b1;
            w_sel   = GW'(v_idx);
         end
      end
   end

   // A grant seen while reset is high would be dropped by the reset edge, so none is offered.
   assign w_grant   = (r_state == S_IDLE) && !reset && div_ready && w_found;
   assign w_timeout = (r_state == S_WAIT) && !div_valid && (r_cnt == CW'(TIMEOUT - 1));

   assign req_ready    = w_grant ? (N_REQ'(1) << w_sel) : '0;
   assign rsp_valid    = (r_state == S_RESP) ? (N_REQ'(1) << r_grant_id) : '0;
   assign rsp_quotient = r_rsp_quotient;
   assign rsp_err      = r_rsp_err;
   assign div_start    = (r_state == S_ISSUE);
   assign div_flush    = w_timeout;
   assign div_dividend = r_div_dividend;
   assign div_divisor  = r_div_divisor;
   assign busy         = (r_state != S_IDLE);
   assign grant_id     = r_grant_id;

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_last_grant   <= GW'(N_REQ - 1);
         r_grant_id     <= '0;
         r_div_dividend <= '0;
         r_div_divisor  <= '0;
         r_rsp_quotient <= '0;
         r_rsp_err      <= 1'b0;
         r_cnt          <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_div_dividend <= req_dividend[int'(w_sel)*WIDTH +: WIDTH];
                  r_div_divisor  <= req_divisor[int'(w_sel)*WIDTH +: WIDTH];
                  r_grant_id     <= w_sel;
                  r_state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (div_valid) begin
                  r_rsp_quotient <= div_quotient;
                  r_rsp_err      <= 1'b0;
                  r_state        <= S_RESP;
               end else if (w_timeout) begin
                  r_rsp_quotient <= '0;
                  r_rsp_err      <= 1'b1;
                  r_state        <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready[r_grant_id]) begin
                  r_last_grant <= r_grant_id;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assert property (@(posedge clk) Q_BITS < WIDTH);
   assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a stub divider and a response scoreboard.
module tb_div_arbiter;

   localparam int WIDTH   = 16;
   localparam int N_REQ   = 4;
   localparam int TIMEOUT = 128;
   localparam int LAT     = 6;

   typedef struct {
      logic [1:0]  id;
      logic [15:0] q;
      logic        err;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic [N_REQ-1:0]       req_valid = '0;
   logic [N_REQ*WIDTH-1:0] req_dividend = '0;
   logic [N_REQ*WIDTH-1:0] req_divisor = '0;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ-1:0]       rsp_valid;
   logic [N_REQ-1:0]       rsp_ready = '1;
   logic [WIDTH-1:0]       rsp_quotient;
   logic                   rsp_err;
   logic                   div_start;
   logic [WIDTH-1:0]       div_dividend;
   logic [WIDTH-1:0]       div_divisor;
   logic                   div_ready;
   logic                   div_valid = 1'b0;
   logic [WIDTH-1:0]       div_quotient = '0;
   logic                   div_flush;
   logic                   busy;
   logic [1:0]             grant_id;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];
   exp_t e;
   int   glog[$];
   int   want[N_REQ];

   always #5 clk = ~clk;

   div_arbiter #(.WIDTH(WIDTH), .Q_BITS(12), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_quotient(rsp_quotient), .rsp_err(rsp_err),
      .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_ready(div_ready), .div_valid(div_valid), .div_quotient(div_quotient),
      .div_flush(div_flush), .busy(busy), .grant_id(grant_id)
   );

   // Stub divider: Q3.12 divide with saturation, reads its live inputs when it finishes.
   function automatic logic [15:0] qdiv(input logic signed [15:0] a, input logic signed [15:0] b);
      int n;
      int q;
      if (b == 0) return a[15] ? 16'h8000 : 16'h7FFF;
      n = int'(a) * 4096;
      q = n / int'(b);
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      return 16'(q);
   endfunction

   logic       s_run = 1'b0;
   logic       hang = 1'b0;
   logic [7:0] s_cnt = '0;
   assign div_ready = !s_run;

   always @(posedge clk) begin
      div_valid <= 1'b0;
      if (div_flush) s_run <= 1'b0;
      else if (div_start) begin
         s_run <= 1'b1;
         s_cnt <= 8'(LAT - 1);
      end else if (s_run && !hang) begin
         if (s_cnt == 0) begin
            s_run        <= 1'b0;
            div_valid    <= 1'b1;
            div_quotient <= qdiv(div_dividend, div_divisor);
         end else s_cnt <= s_cnt - 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every response handshake.
   always @(negedge clk) begin
      if (req_ready != 0) check("req_ready_onehot", 32'($onehot(req_ready)), 1);
      if (!reset && (rsp_valid & rsp_ready) != 0) begin
         if (sb.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 0);
         else begin
            e = sb.pop_front();
            check("rsp_id", 32'(rsp_valid), 32'(1) << e.id);
            check("rsp_quotient", 32'(rsp_quotient), 32'(e.q));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
         end
      end
   end

   task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b);
      req_valid[id] = 1'b1;
      req_dividend[id*WIDTH +: WIDTH] = a;
      req_divisor[id*WIDTH +: WIDTH]  = b;
   endtask

   task automatic push(input int id, input logic [15:0] q, input logic err);
      sb.push_back('{id: 2'(id), q: q, err: err});
   endtask

   task automatic start_req(input int id, input logic [15:0] a, input logic [15:0] b,
                            input bit follow, input bit do_push, input logic [15:0] eq, input bit eerr);
      bit got;
      @(posedge clk); #1;
      set_req(id, a, b);
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         got = (req_ready != 0);
      end
      check("grant_wait", 32'(got), 1);
      check("req_ready", 32'(req_ready), 32'(1) << id);
      if (do_push) push(id, eq, eerr);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      @(negedge clk);
      check("div_start", 32'(div_start), 1);
      check("grant_id", 32'(grant_id), 32'(id));
      check("busy", 32'(busy), 1);
      check("div_dividend", 32'(div_dividend), 32'(a));
      check("div_divisor", 32'(div_divisor), 32'(b));
      @(negedge clk);
      check("div_start_pulse", 32'(div_start), 0);
      if (follow) begin
         got = 1'b0;
         for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            got = div_valid;
         end
         check("div_valid_wait", 32'(got), 1);
         check("dividend_stable", 32'(div_dividend), 32'(a));
         check("divisor_stable", 32'(div_divisor), 32'(b));
         @(negedge clk);
         check("rsp_valid_timing", 32'(rsp_valid), 32'(1) << id);
      end
   endtask

   task automatic run_grants(input int n);
      bit got;
      int id;
      glog.delete();
      for (int k = 0; k < n; k++) begin
         got = 1'b0;
         for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = (req_ready != 0);
         end
         check("rr_grant_wait", 32'(got), 1);
         if (!got) begin
            req_valid = '0;
            return;
         end
         id = 0;
         for (int i = 0; i < N_REQ; i++) if (req_ready[i]) id = i;
         glog.push_back(id);
         want[id]--;
         @(posedge clk); #1;
         if (want[id] <= 0) req_valid[id] = 1'b0;
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 400 && sb.size() != 0; t++) @(negedge clk);
      check("drain", 32'(sb.size()), 0);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
      check({tag, "_rsp_quotient"}, 32'(rsp_quotient), 0);
      check({tag, "_rsp_err"}, 32'(rsp_err), 0);
      check({tag, "_div_start"}, 32'(div_start), 0);
      check({tag, "_div_dividend"}, 32'(div_dividend), 0);
      check({tag, "_div_divisor"}, 32'(div_divisor), 0);
      check({tag, "_div_flush"}, 32'(div_flush), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_grant_id"}, 32'(grant_id), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int rr_order[6];
      int bp_order[3];
      bit early;
      bit seen;
      bit got;
      rr_order = '{0, 1, 2, 3, 0, 1};
      bp_order = '{2, 3, 0};

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_state("init");

      // Basic divides: positive, signed, divide-by-zero saturation.
      start_req(2, 16'h1000, 16'h0800, 1'b1, 1'b1, 16'h2000, 1'b0);
      drain();
      start_req(0, 16'hE800, 16'h0800, 1'b1, 1'b1, 16'hD000, 1'b0);
      drain();
      start_req(0, 16'h1000, 16'h0000, 1'b1, 1'b1, 16'h7FFF, 1'b0);
      drain();

      // Round robin from reset with every requester held valid.
      pulse_reset();
      @(posedge clk); #1;
      set_req(0, 16'h1000, 16'h0800);
      set_req(1, 16'h0800, 16'h1000);
      set_req(2, 16'h3000, 16'h1000);
      set_req(3, 16'hF000, 16'h1000);
      want = '{2, 2, 1, 1};
      push(0, 16'h2000, 1'b0);
      push(1, 16'h0800, 1'b0);
      push(2, 16'h3000, 1'b0);
      push(3, 16'hF000, 1'b0);
      push(0, 16'h2000, 1'b0);
      push(1, 16'h0800, 1'b0);
      run_grants(6);
      drain();
      check("rr_count", 32'(glog.size()), 6);
      for (int k = 0; k < 6 && k < glog.size(); k++) check("rr_order", 32'(glog[k]), 32'(rr_order[k]));

      // Backpressure on requester 1 while the others wait; other rsp_ready bits ignored.
      rsp_ready = 4'b1101;
      start_req(1, 16'h1000, 16'h0800, 1'b1, 1'b1, 16'h2000, 1'b0);
      @(posedge clk); #1;
      set_req(0, 16'hE800, 16'h0800);
      set_req(2, 16'h1000, 16'h0000);
      set_req(3, 16'h0800, 16'h1000);
      push(2, 16'h7FFF, 1'b0);
      push(3, 16'h0800, 1'b0);
      push(0, 16'hD000, 1'b0);
      want = '{1, 0, 1, 1};
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("bp_rsp_valid", 32'(rsp_valid), 32'h2);
         check("bp_quotient", 32'(rsp_quotient), 32'h2000);
         check("bp_req_ready", 32'(req_ready), 0);
         check("bp_div_start", 32'(div_start), 0);
      end
      @(posedge clk); #1;
      rsp_ready = '1;
      run_grants(3);
      drain();
      check("bp_count", 32'(glog.size()), 3);
      for (int k = 0; k < 3 && k < glog.size(); k++) check("bp_order", 32'(glog[k]), 32'(bp_order[k]));

      // Watchdog: divider never answers.
      hang = 1'b1;
      start_req(3, 16'h1000, 16'h0800, 1'b0, 1'b1, 16'h0000, 1'b1);
      early = 1'b0;
      for (int j = 3; j <= TIMEOUT + 1; j++) begin
         @(negedge clk);
         if (j < TIMEOUT + 1 && div_flush) early = 1'b1;
      end
      check("flush_early", 32'(early), 0);
      check("flush_at_timeout", 32'(div_flush), 1);
      @(negedge clk);
      check("flush_one_cycle", 32'(div_flush), 0);
      check("timeout_rsp_valid", 32'(rsp_valid), 32'h8);
      hang = 1'b0;
      drain();
      start_req(0, 16'hE800, 16'h0800, 1'b1, 1'b1, 16'hD000, 1'b0);
      drain();

      // Reset while waiting on the divider; its late result must be ignored.
      start_req(2, 16'h1000, 16'h0800, 1'b0, 1'b0, 16'h0000, 1'b0);
      pulse_reset();
      @(negedge clk);
      check_reset_state("midreset");
      seen = 1'b0;
      got  = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         got = div_valid;
         if (rsp_valid != 0) seen = 1'b1;
      end
      check("late_valid_wait", 32'(got), 1);
      repeat (2) begin
         @(negedge clk);
         if (rsp_valid != 0) seen = 1'b1;
      end
      check("no_rsp_after_reset", 32'(seen), 0);
      @(posedge clk); #1;
      set_req(0, 16'h0800, 16'h1000);
      set_req(1, 16'hF000, 16'h1000);
      want = '{1, 1, 0, 0};
      push(0, 16'h0800, 1'b0);
      push(1, 16'hF000, 1'b0);
      run_grants(2);
      drain();
      check("post_reset_count", 32'(glog.size()), 2);
      if (glog.size() == 2) begin
         check("post_reset_first", 32'(glog[0]), 0);
         check("post_reset_second", 32'(glog[1]), 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin scheduler that shares one iterative fixed-point divider (Q3.12, start/ready/valid interface) among N_REQ requesters. It accepts one request at a time, sequences the divider's start pulse, and holds the operands stable for the whole operation, because the divider's sign correction reads its live inputs. It returns the quotient to the granted requester over a valid/ready response channel and recovers from a hung divider with a watchdog. It sits between the shading/geometry units and the shared divider instance.

## Interface
- WIDTH, 16, operand/quotient width (signed Q3.12)
- Q_BITS, 12, fractional bits (passed through for documentation/assertions only)
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 128, max cycles waiting for div_valid before abort
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  N_REQ  per-requester request valid
- req_dividend  in  N_REQ*WIDTH  requester i at [i*WIDTH +: WIDTH]
- req_divisor  in  N_REQ*WIDTH  same packing
- req_ready  out  N_REQ  one-hot accept strobe (combinational)
- rsp_valid  out  N_REQ  one-hot response valid
- rsp_ready  in  N_REQ  per-requester response ready
- rsp_quotient  out  WIDTH  registered result
- rsp_err  out  1  result is a timeout abort; qualified by rsp_valid
- div_start  out  1  one-cycle start pulse to divider
- div_dividend, div_divisor  out  WIDTH each  registered operands to divider
- div_ready  in  1  divider idle
- div_valid  in  1  divider one-cycle done pulse
- div_quotient  in  WIDTH  divider result
- div_flush  out  1  one-cycle pulse on timeout, ORed into divider reset at top level
- busy  out  1  high in any state except IDLE
- grant_id  out  $clog2(N_REQ)  index of current/last granted requester

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid and div_ready: select the first set req_valid searching from last_grant+1 upward, with modulo-N_REQ wrap-around.
  - Assert req_ready[sel] combinationally that cycle.
  - Latch operands into div_dividend/div_divisor; set grant_id=sel; go to ISSUE.
  - If div_ready=0: no grant; req_ready all 0.
- ISSUE: div_start=1 for exactly this cycle; go to WAIT; clear watchdog counter.
- WAIT:
  - div_dividend/div_divisor held unchanged.
  - On div_valid: rsp_quotient<=div_quotient, rsp_err<=0, go to RESP.
  - Otherwise the counter increments; when it reaches TIMEOUT-1 without div_valid: rsp_quotient<=0, rsp_err<=1, div_flush=1 for one cycle, go to RESP.
- RESP:
  - rsp_valid[grant_id]=1; rsp_quotient/rsp_err stable.
  - On rsp_ready[grant_id]: last_grant<=grant_id, go to IDLE.
  - rsp_ready of other requesters is ignored.
- Operands are held until the next grant; they are never changed while busy.
- No arithmetic in this block: quotient passes through unmodified, including the divider's saturation of divide-by-zero to 0x7FFF/0x8000.
- div_valid outside WAIT (e.g. after a reset or flush) is ignored.
- Requester protocol: hold req_valid and operands until req_ready. Deasserting req_valid before grant is legal and simply drops the request.

## Timing
- Reset values:
  - State IDLE; last_grant=N_REQ-1, so requester 0 wins first.
  - req_ready=0, rsp_valid=0, rsp_quotient=0, rsp_err=0.
  - div_start=0, div_dividend=0, div_divisor=0, div_flush=0, busy=0, grant_id=0.
- Cycle 0: req_valid&req_ready handshake.
- Cycle 1: div_start=1.
- Cycle k: div_valid (k = 1 + divider latency).
- Cycle k+1: rsp_valid high.
- Min request-to-response latency is divider latency + 2.
- Back-to-back throughput: next grant no earlier than the cycle after the rsp handshake. One divide in flight maximum.
- Simultaneous events: rsp handshake and a new req_valid in the same cycle → the new request is seen in IDLE the following cycle.
- A requester re-asserting immediately after its own response yields to any other pending requester (fairness).
- Reset mid-operation (any state): all outputs return to reset values next edge; in-flight transaction dropped; no response issued.
- Watchdog: abort occurs TIMEOUT cycles after div_start; div_flush coincides with the WAIT→RESP transition.

## Test plan
- Single request, requester 2: 0x1000 / 0x0800 → req_ready[2] same cycle, div_start next cycle, rsp_valid[2] with rsp_quotient=0x2000, rsp_err=0; grant_id=2.
- Signed/zero cases via requester 0:
  - 0xE800 / 0x0800 → 0xD000.
  - 0x1000 / 0x0000 → 0x7FFF.
  - Operands on div_* are stable from start through div_valid.
- All four req_valid held high with rsp_ready tied high → grant order 0,1,2,3,0,1; never two req_ready bits in one cycle.
- Backpressure: rsp_ready low for 10 cycles while the others request → rsp_valid and 0x2000 held 10 cycles, no req_ready asserted, div_start stays 0.
- Stub divider never pulses div_valid → exactly TIMEOUT cycles after div_start: div_flush one-cycle pulse, rsp_valid with rsp_err=1, rsp_quotient=0; the next request completes normally.
- Assert reset for one cycle in WAIT → all outputs at reset values next cycle; a late div_valid produces no rsp_valid; the next grant goes to requester 0.
